// File: rtl/ppu_pkg.sv
// Shared PPU timing constants and types for the raster timing generator.
package ppu_pkg;

    // Raster geometry of the supported consoles.
    localparam int NTSC_DOTS         = 341;
    localparam int NTSC_LINES        = 262;
    localparam int NTSC_VBLANK_LINE  = 241;

    localparam int PAL_DOTS          = 341;
    localparam int PAL_LINES         = 312;
    localparam int PAL_VBLANK_LINE   = 241;

    localparam int DENDY_DOTS        = 341;
    localparam int DENDY_LINES       = 312;
    localparam int DENDY_VBLANK_LINE = 291;

    // Lines 0..239 carry picture on every variant.
    localparam int VISIBLE_LINES     = 240;

    // Default counter width, wide enough for every variant above.
    localparam int POS_W             = 9;

    // A raster position as seen by the fetch pipeline and mapper.
    typedef struct packed {
        logic [POS_W-1:0] cycle;
        logic [POS_W-1:0] scanline;
    } ppu_pos_t;

endpackage

// File: rtl/ppu_vblank_ctrl.sv
// VBlank status flag with set/clear priority, $2002 read race, and NMI level.
module ppu_vblank_ctrl (
    input  logic clk,
    input  logic reset,
    input  logic set_strobe,
    input  logic clr_strobe,
    input  logic status_rd,
    input  logic nmi_en,
    output logic vblank_flag,
    output logic nmi
);

    // Flag register: reset, pre-render clear, status read clear, then set.
    // A read landing on the set edge wins, so that frame never raises the flag.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of block ordering.
        if (reset) begin
            vblank_flag <= 1'b0;
        end else if (clr_strobe) begin
            vblank_flag <= 1'b0;
        end else if (status_rd) begin
            vblank_flag <= 1'b0;
        end else if (set_strobe) begin
            vblank_flag <= 1'b1;
        end
    end

    // NMI is a pure level; enabling it while the flag is high raises it at once.
    always_comb begin
        nmi = vblank_flag & nmi_en;
    end

endmodule

// File: rtl/ppu_timing_gen.sv
// PPU raster timing: dot/scanline counters, odd-frame dot skip, strobes,
// and the VBlank flag / NMI controller.
module ppu_timing_gen
    import ppu_pkg::*;
#(
    parameter int DOTS_PER_LINE   = NTSC_DOTS,
    parameter int LINES_PER_FRAME = NTSC_LINES,
    parameter int VBLANK_LINE     = NTSC_VBLANK_LINE,
    parameter int ODD_SKIP        = 1,
    parameter int CW              = POS_W
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ce,
    input  logic          rendering_en,
    input  logic          nmi_en,
    input  logic          status_rd,
    output logic [CW-1:0] cycle,
    output logic [CW-1:0] scanline,
    output logic          vblank_flag,
    output logic          nmi,
    output logic          frame_odd,
    output logic          visible,
    output logic          prerender,
    output logic          clr_status,
    output logic          frame_start
);

    localparam logic [CW-1:0] LAST_DOT  = CW'(DOTS_PER_LINE - 1);
    localparam logic [CW-1:0] SKIP_DOT  = CW'(DOTS_PER_LINE - 3);
    localparam logic [CW-1:0] PRE_LINE  = CW'(LINES_PER_FRAME - 1);
    localparam logic [CW-1:0] VBL_LINE  = CW'(VBLANK_LINE);
    localparam logic [CW-1:0] VIS_LINES = CW'(VISIBLE_LINES);
    localparam logic [CW-1:0] DOT_ONE   = CW'(1);
    localparam bit            SKIP_ON   = (ODD_SKIP != 0);

    logic [CW-1:0] cycle_q, cycle_d;
    logic [CW-1:0] line_q, line_d;
    logic          odd_q, odd_d;
    logic          skip_now;
    logic          set_vbl;
    logic          clr_vbl;

    // On odd frames with rendering on, dot 338 of pre-render jumps straight
    // to the last dot; rendering_en only matters on that one dot.
    always_comb begin
        skip_now = SKIP_ON & rendering_en & odd_q &
                   (line_q == PRE_LINE) & (cycle_q == SKIP_DOT);
    end

    // Next raster position and frame parity; everything holds while ce=0.
    always_comb begin
        // NOTE: every output of this block is defaulted first so no path
        // leaves a variable unassigned and no latch is inferred.
        cycle_d = cycle_q;
        line_d  = line_q;
        odd_d   = odd_q;
        if (ce) begin
            if (skip_now) begin
                cycle_d = LAST_DOT;
            end else if (cycle_q == LAST_DOT) begin
                cycle_d = '0;
                if (line_q == PRE_LINE) begin
                    line_d = '0;
                    odd_d  = ~odd_q;
                end else begin
                    line_d = line_q + CW'(1);
                end
            end else begin
                cycle_d = cycle_q + CW'(1);
            end
        end
    end

    // Position and parity registers; reset restarts the frame at (0,0).
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_q <= '0;
            line_q  <= '0;
            odd_q   <= 1'b0;
        end else begin
            cycle_q <= cycle_d;
            line_q  <= line_d;
            odd_q   <= odd_d;
        end
    end

    // Dot-qualified event strobes and line decodes.
    always_comb begin
        prerender   = (line_q == PRE_LINE);
        visible     = (line_q < VIS_LINES);
        set_vbl     = ce & (line_q == VBL_LINE) & (cycle_q == DOT_ONE);
        clr_vbl     = ce & prerender & (cycle_q == DOT_ONE);
        clr_status  = clr_vbl;
        frame_start = ce & (line_q == '0) & (cycle_q == '0);
    end

    assign cycle     = cycle_q;
    assign scanline  = line_q;
    assign frame_odd = odd_q;

    ppu_vblank_ctrl u_vblank (
        .clk         (clk),
        .reset       (reset),
        .set_strobe  (set_vbl),
        .clr_strobe  (clr_vbl),
        .status_rd   (status_rd & ce),
        .nmi_en      (nmi_en),
        .vblank_flag (vblank_flag),
        .nmi         (nmi)
    );

endmodule
